facto_core_gen: RTL and testbench

FACTO_CORE_GEN -- requirements
Module: facto_core_gen

---
 rtl/facto_core_gen.sv | 208 ++++++++++++++++++++
 tb/tb_facto_core_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/facto_core_gen.sv
// rtl/facto_core_gen.sv - register-mapped factorial / double-factorial engine
// Each factor is folded into a 2*DATA_W accumulator by a DATA_W-cycle shift-add multiplier.
module facto_core_gen #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [15:0]       s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic              interrupt
);
  localparam int ACC_W = 2 * DATA_W;
  localparam int PRD_W = 3 * DATA_W;
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [4:0] IDX_OPERAND = 5'd0;
  localparam logic [4:0] IDX_OPSTART = 5'd1;
  localparam logic [4:0] IDX_OPCLEAR = 5'd2;
  localparam logic [4:0] IDX_OPDONE  = 5'd3;
  localparam logic [4:0] IDX_INTREN  = 5'd4;
  localparam logic [4:0] IDX_RESH    = 5'd5;
  localparam logic [4:0] IDX_RESL    = 5'd6;
  localparam logic [4:0] IDX_MODE    = 5'd7;
  localparam logic [4:0] IDX_STATUS  = 5'd8;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  operand_q, operand_d;
  logic [DATA_W-1:0]  opstart_q, opstart_d;
  logic [DATA_W-1:0]  opclear_q, opclear_d;
  logic [DATA_W-1:0]  intr_en_q, intr_en_d;
  logic [DATA_W-1:0]  mode_q, mode_d;
  logic               opdone_q, opdone_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]  k_q, k_d;
  logic               setup_q, setup_d;
  logic [PRD_W-1:0]   prod_q, prod_d;
  logic [PRD_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]  mplier_q, mplier_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

  logic [4:0]         reg_idx;
  logic               wr_en;
  logic               busy;
  logic               start_req;
  logic               clear_req;
  logic [PRD_W-1:0]   prod_sum;
  logic [DATA_W-1:0]  next_k;
  logic               unused_addr;

  assign unused_addr = ^{s_addr[15:8], s_addr[2:0]};
  assign interrupt   = opdone_q & intr_en_q[0];

  always_comb begin
    reg_idx   = s_addr[7:3];
    wr_en     = s_sel & s_wr;
    busy      = (state_q == ST_BUSY);
    start_req = wr_en && (reg_idx == IDX_OPSTART) && s_din[0] && !busy;
    clear_req = wr_en && (reg_idx == IDX_OPCLEAR) && s_din[0];
    prod_sum  = prod_q + (mplier_q[0] ? mcand_q : '0);
    next_k    = mode_q[0] ? (k_q - DATA_W'(2)) : (k_q - DATA_W'(1));
  end

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    opstart_d = opstart_q;
    opclear_d = opclear_q;
    intr_en_d = intr_en_q;
    mode_d    = mode_q;
    opdone_d  = opdone_q;
    ovf_d     = ovf_q;
    acc_d     = acc_q;
    k_d       = k_q;
    setup_d   = setup_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    bit_cnt_d = bit_cnt_q;

    if (wr_en) begin
      case (reg_idx)
        IDX_OPERAND: if (!busy) operand_d = s_din;
        IDX_OPSTART: opstart_d = s_din;
        IDX_OPCLEAR: opclear_d = s_din;
        IDX_INTREN:  intr_en_d = s_din;
        IDX_MODE:    if (!busy) mode_d = s_din;
        default: ;
      endcase
    end

    case (state_q)
      ST_BUSY: begin
        if (setup_q) begin
          // One-time check cycle: operands 0/1 have no factors and finish here.
          setup_d = 1'b0;
          if (k_q < DATA_W'(2)) begin
            state_d  = ST_DONE;
            opdone_d = 1'b1;
          end else begin
            prod_d    = '0;
            mcand_d   = PRD_W'(acc_q);
            mplier_d  = k_q;
            bit_cnt_d = '0;
          end
        end else begin
          prod_d    = prod_sum;
          mcand_d   = mcand_q << 1;
          mplier_d  = mplier_q >> 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            acc_d = prod_sum[ACC_W-1:0];
            if (|prod_sum[PRD_W-1:ACC_W]) ovf_d = 1'b1;
            k_d = next_k;
            // Chain straight into the next factor so no cycle is lost between them.
            if (next_k < DATA_W'(2)) begin
              state_d  = ST_DONE;
              opdone_d = 1'b1;
            end else begin
              prod_d    = '0;
              mcand_d   = PRD_W'(prod_sum[ACC_W-1:0]);
              mplier_d  = next_k;
              bit_cnt_d = '0;
            end
          end
        end
      end
      default: ;
    endcase

    if (start_req) begin
      state_d  = ST_BUSY;
      acc_d    = ACC_W'(1);
      k_d      = operand_q;
      opdone_d = 1'b0;
      ovf_d    = 1'b0;
      setup_d  = 1'b1;
    end

    if (clear_req) begin
      state_d  = ST_IDLE;
      acc_d    = ACC_W'(1);
      opdone_d = 1'b0;
      ovf_d    = 1'b0;
      setup_d  = 1'b0;
    end
  end

  always_comb begin
    s_dout = '0;
    if (s_sel && !s_wr) begin
      case (reg_idx)
        IDX_OPERAND: s_dout = operand_q;
        IDX_OPSTART: s_dout = opstart_q;
        IDX_OPCLEAR: s_dout = opclear_q;
        IDX_OPDONE:  s_dout = DATA_W'(opdone_q);
        IDX_INTREN:  s_dout = intr_en_q;
        IDX_RESH:    s_dout = acc_q[ACC_W-1:DATA_W];
        IDX_RESL:    s_dout = acc_q[DATA_W-1:0];
        IDX_MODE:    s_dout = mode_q;
        IDX_STATUS:  s_dout = DATA_W'({busy, ovf_q});
        default:     s_dout = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      operand_q <= '0;
      opstart_q <= '0;
      opclear_q <= '0;
      intr_en_q <= '0;
      mode_q    <= '0;
      opdone_q  <= 1'b0;
      ovf_q     <= 1'b0;
      acc_q     <= ACC_W'(1);
      k_q       <= '0;
      setup_q   <= 1'b0;
      prod_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      opstart_q <= opstart_d;
      opclear_q <= opclear_d;
      intr_en_q <= intr_en_d;
      mode_q    <= mode_d;
      opdone_q  <= opdone_d;
      ovf_q     <= ovf_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      setup_q   <= setup_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_facto_core_gen.sv
// tb/tb_facto_core_gen.sv - scoreboard bench for facto_core_gen at DATA_W=8
module tb_facto_core_gen;
  localparam int W = 8;
  localparam int I_OPERAND = 0, I_OPSTART = 1, I_OPCLEAR = 2, I_OPDONE = 3, I_INTREN = 4;
  localparam int I_RESH = 5, I_RESL = 6, I_MODE = 7, I_STATUS = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         s_sel = 1'b0;
  logic         s_wr = 1'b0;
  logic [15:0]  s_addr = '0;
  logic [W-1:0] s_din = '0;
  logic [W-1:0] s_dout;
  logic         interrupt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    string name;
    int    exp;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      done_q[$];
  rd_exp_t cur;
  logic    int_prev = 1'b0;

  facto_core_gen #(.DATA_W(W)) dut (
    .clk(clk), .reset_n(reset_n), .s_sel(s_sel), .s_wr(s_wr),
    .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout), .interrupt(interrupt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: product of n, n-step, ... while >= 2, kept mod 2^16 with overflow flag.
  function automatic void model(input int n, input bit dbl, output int acc, output bit ovf, output int f);
    longint a;
    a = 1; ovf = 1'b0; f = 0;
    for (int k = n; k >= 2; k -= (dbl ? 2 : 1)) begin
      a = a * k;
      if (a >= 65536) ovf = 1'b1;
      a = a % 65536;
      f++;
    end
    acc = int'(a);
  endfunction

  always @(negedge clk) begin
    if (reset_n && s_sel && !s_wr) begin
      if (rd_q.size() == 0) begin
        check("read_unexpected", 1, 0);
      end else begin
        cur = rd_q.pop_front();
        check(cur.name, 32'(s_dout), cur.exp);
      end
    end
  end

  always @(negedge clk) begin
    if (interrupt && !int_prev) begin
      if (done_q.size() == 0) check("done_unexpected", 1, 0);
      else check("done_cycle", cyc, done_q.pop_front());
    end
    int_prev = interrupt;
  end

  task automatic bus_write(input int idx, input int d);
    s_sel = 1'b1; s_wr = 1'b1;
    s_addr = {8'($urandom), 5'(idx), 3'($urandom)};
    s_din = W'(d);
    @(posedge clk); #1;
    s_sel = 1'b0; s_wr = 1'b0;
  endtask

  task automatic bus_read(input int idx, input int exp, input string name);
    rd_q.push_back('{name, exp});
    s_sel = 1'b1; s_wr = 1'b0;
    s_addr = {8'($urandom), 5'(idx), 3'($urandom)};
    @(posedge clk); #1;
    s_sel = 1'b0;
  endtask

  task automatic reset_reads(input string tag);
    bus_read(I_OPERAND, 0, {tag, "_operand"});
    bus_read(I_OPSTART, 0, {tag, "_opstart"});
    bus_read(I_OPCLEAR, 0, {tag, "_opclear"});
    bus_read(I_OPDONE,  0, {tag, "_opdone"});
    bus_read(I_INTREN,  0, {tag, "_intren"});
    bus_read(I_RESH,    0, {tag, "_result_h"});
    bus_read(I_RESL,    1, {tag, "_result_l"});
    bus_read(I_MODE,    0, {tag, "_mode"});
    bus_read(I_STATUS,  0, {tag, "_status"});
  endtask

  task automatic run_op(input int n, input bit dbl, input bit setup, input bit poke);
    int exp_acc;
    bit ovf;
    int f;
    int waited;
    model(n, dbl, exp_acc, ovf, f);
    if (setup) begin
      bus_write(I_OPERAND, n);
      bus_write(I_MODE, int'(dbl));
    end
    bus_write(I_OPSTART, 1);
    done_q.push_back(cyc + 1 + f * W);
    if (poke) begin
      bus_write(I_OPSTART, 8'h81);
      bus_read(I_OPSTART, 8'h81, "busy_opstart_stored");
      bus_read(I_STATUS, 2, "busy_status");
    end
    waited = 0;
    while (!interrupt && waited < 1200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!interrupt) begin
      check($sformatf("done_timeout_n%0d", n), 0, 1);
      if (done_q.size() > 0) void'(done_q.pop_front());
    end
    bus_read(I_RESH, (exp_acc >> 8) & 255, $sformatf("n%0d_m%0d_result_h", n, dbl));
    bus_read(I_RESL, exp_acc & 255, $sformatf("n%0d_m%0d_result_l", n, dbl));
    bus_read(I_STATUS, int'(ovf), $sformatf("n%0d_m%0d_status", n, dbl));
    bus_read(I_OPDONE, 1, $sformatf("n%0d_m%0d_opdone", n, dbl));
    check($sformatf("n%0d_interrupt", n), 32'(interrupt), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit dbl;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("interrupt_after_reset", 32'(interrupt), 0);
    reset_reads("por");
    bus_read(9, 0, "unmapped_9");
    bus_read(31, 0, "unmapped_31");
    bus_write(I_INTREN, 1);

    run_op(5, 1'b0, 1'b1, 1'b0);
    run_op(9, 1'b0, 1'b1, 1'b1);
    run_op(7, 1'b1, 1'b1, 1'b0);
    run_op(0, 1'b0, 1'b1, 1'b0);
    run_op(1, 1'b0, 1'b1, 1'b0);

    // Abort: start 6!, clear at start+10, restart at start+12.
    bus_write(I_OPERAND, 6);
    bus_write(I_MODE, 0);
    bus_write(I_OPSTART, 1);
    bus_read(I_STATUS, 2, "abort_busy_status");
    repeat (8) begin @(posedge clk); #1; end
    bus_write(I_OPCLEAR, 1);
    bus_read(I_RESL, 1, "abort_result_l");
    run_op(6, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 20));
      dbl = 1'($urandom_range(0, 1));
      run_op(n, dbl, 1'b1, 1'b0);
    end

    // Reset in the middle of BUSY; operand/mode writes while busy must be dropped.
    bus_write(I_OPERAND, 5);
    bus_write(I_MODE, 0);
    bus_write(I_OPSTART, 1);
    bus_write(I_OPERAND, 9);
    bus_write(I_MODE, 1);
    bus_read(I_OPERAND, 5, "busy_operand_hold");
    bus_read(I_MODE, 0, "busy_mode_hold");
    bus_read(I_STATUS, 2, "busy_status_pre_rst");
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("interrupt_mid_rst", 32'(interrupt), 0);
    reset_reads("midrst");
    repeat (40) begin @(posedge clk); #1; end
    bus_read(I_OPDONE, 0, "post_rst_opdone");
    bus_read(I_STATUS, 0, "post_rst_status");

    repeat (2) begin @(posedge clk); #1; end
    check("read_queue_drained", rd_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
